// File: rtl/snappy_pkg.sv
// Shared types and constants for the copy-engine history read path.
package snappy_pkg;

    localparam int RES_W    = 89;
    localparam int DATA_W   = 64;
    localparam int ADDR_W   = 16;
    localparam int LAST_BIT = 88;
    localparam int MASK_LSB = 80;
    localparam int DEST_LSB = 64;
    localparam int MASK_W   = 8;
    localparam int META_W   = 1 + MASK_W + ADDR_W;

    typedef enum logic {
        IDLE,
        ISSUE
    } state_t;

    typedef struct packed {
        logic              last;
        logic [MASK_W-1:0] mask;
        logic [ADDR_W-1:0] dest;
    } beat_meta_t;

    // Byte lanes off..off+cnt-1 of a 64-bit word; cnt is 1..8.
    function automatic logic [MASK_W-1:0] beat_mask(input logic [2:0] off, input logic [3:0] cnt);
        logic [15:0] m;
        m = (16'h00FF >> (4'd8 - cnt)) << off;
        return m[MASK_W-1:0];
    endfunction

endpackage

// File: rtl/rd_meta_pipe.sv
// Delay line carrying a valid bit and beat metadata so it lines up with
// data coming back from a fixed-latency memory read port.
module rd_meta_pipe
    import snappy_pkg::*;
#(
    parameter int RD_LAT = 2,
    parameter int MW     = META_W
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          issue_vld,
    input  logic [MW-1:0] issue_meta,
    output logic          ret_vld,
    output logic [MW-1:0] ret_meta
);

    logic          vld_p  [RD_LAT];
    logic [MW-1:0] meta_p [RD_LAT];

    always_ff @(posedge clk) begin
        if (srst) begin
            for (int i = 0; i < RD_LAT; i++) vld_p[i] <= 1'b0;
        end else begin
            vld_p[0] <= issue_vld;
            for (int i = 1; i < RD_LAT; i++) vld_p[i] <= vld_p[i-1];
        end
    end

    // Metadata is qualified by the valid chain, so it needs no reset.
    always_ff @(posedge clk) begin
        meta_p[0] <= issue_meta;
        for (int i = 1; i < RD_LAT; i++) meta_p[i] <= meta_p[i-1];
    end

    assign ret_vld  = vld_p[RD_LAT-1];
    assign ret_meta = meta_p[RD_LAT-1];

endmodule

// File: rtl/history_read_issuer.sv
// Splits copy commands into 8-byte history reads and pushes the tagged
// read results into the downstream result FIFO without ever overflowing it.
module history_read_issuer
    import snappy_pkg::*;
#(
    parameter int RD_LAT       = 2,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_src_addr,
    input  logic [ADDR_W-1:0] cmd_dest_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    output logic              mem_rd_en,
    output logic [12:0]       mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [RES_W-1:0]  fifo_din,
    output logic              fifo_wr_en,
    input  logic              fifo_prog_full,
    input  logic              fifo_full,
    output logic              busy,
    output logic              ovf_err
);

    localparam int              IF_W   = $clog2(MAX_INFLIGHT + 1);
    localparam logic [IF_W-1:0] IF_MAX = IF_W'(MAX_INFLIGHT);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] src, dest, rem;
    logic [IF_W-1:0]   inflight;
    logic              accept, issue, push, last_beat;
    logic [2:0]        off;
    logic [3:0]        room, cnt;
    beat_meta_t        meta_p0, ret_meta;
    logic              ret_vld;

    assign accept    = cmd_valid & cmd_ready;
    assign push      = fifo_wr_en;
    assign off       = src[2:0];
    assign room      = 4'd8 - {1'b0, off};
    assign cnt       = (rem < {12'd0, room}) ? rem[3:0] : room;
    assign last_beat = (rem == {12'd0, cnt});
    assign busy      = (state == ISSUE) || (inflight != '0);

    always_ff @(posedge clk) begin
        if (srst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                if (accept && (cmd_len != '0)) state_nxt = ISSUE;
            end
            ISSUE: begin
                // prog_full low means the FIFO holds <=2, leaving room for every read in flight.
                issue = !fifo_prog_full && (inflight < IF_MAX);
                if (issue && last_beat) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p0: registered read strobe, address and beat metadata.
    always_ff @(posedge clk) begin
        if (srst) begin
            cmd_ready   <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            inflight    <= '0;
            fifo_wr_en  <= 1'b0;
            fifo_din    <= '0;
            ovf_err     <= 1'b0;
        end else begin
            cmd_ready <= (state_nxt == IDLE);
            mem_rd_en <= issue;
            if (issue) mem_rd_addr <= src[ADDR_W-1:3];
            if (issue && !push)      inflight <= inflight + 1'b1;
            else if (!issue && push) inflight <= inflight - 1'b1;
            fifo_wr_en <= ret_vld;
            if (ret_vld) fifo_din <= {ret_meta.last, ret_meta.mask, ret_meta.dest, mem_rd_data};
            if (fifo_wr_en && fifo_full) ovf_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            src  <= cmd_src_addr;
            dest <= cmd_dest_addr;
            rem  <= cmd_len;
        end else if (issue) begin
            src  <= src + {12'd0, cnt};
            dest <= dest + {12'd0, cnt};
            rem  <= rem - {12'd0, cnt};
        end
        if (issue) begin
            meta_p0.last <= last_beat;
            meta_p0.mask <= beat_mask(off, cnt);
            meta_p0.dest <= dest;
        end
    end

    // Stage p1..pRD_LAT: metadata travels beside the BRAM read.
    rd_meta_pipe #(
        .RD_LAT(RD_LAT),
        .MW    (META_W)
    ) u_meta_pipe (
        .clk       (clk),
        .srst      (srst),
        .issue_vld (mem_rd_en),
        .issue_meta(meta_p0),
        .ret_vld   (ret_vld),
        .ret_meta  (ret_meta)
    );

endmodule

// File: tb/tb_history_read_issuer.sv
// Bench for history_read_issuer: BRAM and FIFO models plus a byte-level
// reference model of how copies split into tagged word reads.
module tb_history_read_issuer;

    localparam int RD_LAT       = 2;
    localparam int MAX_INFLIGHT = 4;

    logic        clk, srst;
    logic        cmd_valid, cmd_ready;
    logic [15:0] cmd_src_addr, cmd_dest_addr, cmd_len;
    logic        mem_rd_en;
    logic [12:0] mem_rd_addr;
    logic [63:0] mem_rd_data;
    logic [88:0] fifo_din;
    logic        fifo_wr_en, fifo_prog_full, fifo_full, busy, ovf_err;

    history_read_issuer #(.RD_LAT(RD_LAT), .MAX_INFLIGHT(MAX_INFLIGHT)) dut (
        .clk(clk), .srst(srst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_src_addr(cmd_src_addr), .cmd_dest_addr(cmd_dest_addr), .cmd_len(cmd_len),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en), .fifo_prog_full(fifo_prog_full),
        .fifo_full(fifo_full), .busy(busy), .ovf_err(ovf_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_checks = 0, n_errors = 0;
    int          rd_cnt = 0, push_cnt = 0, tb_if = 0, max_if = 0;
    int          fifo_cnt = 0, drain_pct = 70;
    bit          prev_push = 0, force_pf = 0, force_full = 0, busy_seen = 0;
    logic [88:0] exp_push_q[$];
    logic [12:0] exp_addr_q[$];
    logic [24:0] meta_log[$];
    logic [12:0] addr_log[$];

    task automatic check(input string tag, input logic [88:0] obs, input logic [88:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mem_word(input logic [12:0] w);
        return {3'b000, w, 3'b101, w, 3'b011, w, ~{3'b000, w}} ^ 64'h0123_4567_89ab_cdef;
    endfunction

    // BRAM: data for a strobe seen in cycle c is presented in cycle c+RD_LAT; garbage otherwise.
    logic        bram_vld [RD_LAT];
    logic [12:0] bram_addr[RD_LAT];
    logic [63:0] junk;
    always @(posedge clk) begin
        bram_vld[0]  <= mem_rd_en;
        bram_addr[0] <= mem_rd_addr;
        for (int i = 1; i < RD_LAT; i++) begin
            bram_vld[i]  <= bram_vld[i-1];
            bram_addr[i] <= bram_addr[i-1];
        end
        junk <= {$urandom, $urandom};
    end
    assign mem_rd_data    = bram_vld[RD_LAT-1] ? mem_word(bram_addr[RD_LAT-1]) : junk;
    assign fifo_prog_full = force_pf || (fifo_cnt >= 3);
    assign fifo_full      = force_full || (fifo_cnt >= 8);

    // Reference: walk the copy byte by byte; each new source word opens a beat.
    task automatic model_cmd(input logic [15:0] s, input logic [15:0] d, input logic [15:0] len);
        logic [15:0] a, bd;
        logic [12:0] w;
        logic [7:0]  m;
        bit          open;
        open = 0; w = '0; bd = '0; m = '0;
        for (int k = 0; k < int'(len); k++) begin
            a = s + 16'(k);
            if (open && a[15:3] != w) begin
                exp_addr_q.push_back(w);
                exp_push_q.push_back({1'b0, m, bd, mem_word(w)});
                open = 0;
            end
            if (!open) begin
                w = a[15:3]; bd = d + 16'(k); m = '0; open = 1;
            end
            m[a[2:0]] = 1'b1;
        end
        if (open) begin
            exp_addr_q.push_back(w);
            exp_push_q.push_back({1'b1, m, bd, mem_word(w)});
        end
    endtask

    always @(posedge clk) begin
        bit pop;
        #1;
        busy_seen = busy_seen | busy;
        if (mem_rd_en) begin
            rd_cnt++; tb_if++;
            if (tb_if > max_if) max_if = tb_if;
            addr_log.push_back(mem_rd_addr);
            if (exp_addr_q.size() == 0) check("rd_unexpected", 1, 0);
            else check("rd_addr", mem_rd_addr, exp_addr_q.pop_front());
        end
        if (fifo_wr_en) begin
            push_cnt++; tb_if--;
            meta_log.push_back(fifo_din[88:64]);
            if (exp_push_q.size() == 0) check("push_unexpected", 1, 0);
            else check("push_word", fifo_din, exp_push_q.pop_front());
        end
        pop = (fifo_cnt > 0) && ($urandom_range(0, 99) < drain_pct);
        if (prev_push && !force_full) begin
            check("fifo_room", fifo_cnt < 8, 1);
            fifo_cnt++;
        end
        if (pop) fifo_cnt--;
        prev_push = fifo_wr_en;
    end

    task automatic send_cmd(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l, output int waited);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_src_addr = s; cmd_dest_addr = d; cmd_len = l;
        waited = 0;
        while (!cmd_ready && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (!cmd_ready) check("cmd_accept_timeout", 0, 1);
        else model_cmd(s, d, l);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((busy || exp_push_q.size() != 0) && k < 4000) begin
            @(negedge clk);
            k++;
        end
        check("idle_reached", busy || (exp_push_q.size() != 0), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        srst = 1'b1;
        exp_push_q.delete();
        exp_addr_q.delete();
        tb_if = 0;
        repeat (2) @(negedge clk);
        srst = 1'b0;
    endtask

    initial begin
        int w, n0, a0, rd0, p0;
        logic [15:0] s, d, l;
        srst = 1'b1; cmd_valid = 1'b0;
        cmd_src_addr = '0; cmd_dest_addr = '0; cmd_len = '0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_mem_rd_en", mem_rd_en, 0);
        check("rst_mem_rd_addr", mem_rd_addr, 0);
        check("rst_fifo_wr_en", fifo_wr_en, 0);
        check("rst_fifo_din", fifo_din, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf_err", ovf_err, 0);
        srst = 1'b0;
        @(negedge clk);
        check("post_rst_wr_en", fifo_wr_en, 0);

        // aligned two-word copy
        n0 = meta_log.size(); a0 = addr_log.size();
        send_cmd(16'h0008, 16'h0100, 16'd16, w);
        wait_idle();
        check("t1_beats", meta_log.size() - n0, 2);
        check("t1_meta0", meta_log[n0],   {1'b0, 8'hFF, 16'h0100});
        check("t1_meta1", meta_log[n0+1], {1'b1, 8'hFF, 16'h0108});
        check("t1_addr0", addr_log[a0],   13'h0001);
        check("t1_addr1", addr_log[a0+1], 13'h0002);

        // unaligned short copy straddling a word boundary
        n0 = meta_log.size();
        send_cmd(16'h0005, 16'h0200, 16'd5, w);
        wait_idle();
        check("t2_beats", meta_log.size() - n0, 2);
        check("t2_meta0", meta_log[n0],   {1'b0, 8'hE0, 16'h0200});
        check("t2_meta1", meta_log[n0+1], {1'b1, 8'h03, 16'h0203});

        // wrap of both address spaces
        n0 = meta_log.size(); a0 = addr_log.size();
        send_cmd(16'hFFFC, 16'hFFFE, 16'd8, w);
        wait_idle();
        check("t4_addr0", addr_log[a0],   13'h1FFF);
        check("t4_addr1", addr_log[a0+1], 13'h0000);
        check("t4_meta0", meta_log[n0],   {1'b0, 8'hF0, 16'hFFFE});
        check("t4_meta1", meta_log[n0+1], {1'b1, 8'h0F, 16'h0002});

        // zero-length command
        rd0 = rd_cnt; p0 = push_cnt; busy_seen = 0;
        send_cmd(16'h0123, 16'h0456, 16'd0, w);
        repeat (6) @(negedge clk);
        check("t5_accept_wait", w, 0);
        check("t5_no_reads", rd_cnt - rd0, 0);
        check("t5_no_pushes", push_cnt - p0, 0);
        check("t5_busy_seen", busy_seen, 0);

        // throttle held by prog_full
        force_pf = 1; rd0 = rd_cnt; max_if = 0;
        send_cmd(16'h0000, 16'h0800, 16'd64, w);
        repeat (20) @(negedge clk);
        check("t3_blocked_reads", rd_cnt - rd0, 0);
        force_pf = 0;
        wait_idle();
        check("t3_resumed_reads", rd_cnt - rd0, 8);
        check("t3_inflight_max", max_if <= MAX_INFLIGHT, 1);

        // reset with reads in flight
        rd0 = rd_cnt; w = 0;
        drain_pct = 100;
        send_cmd(16'h0100, 16'h0400, 16'd128, w);
        w = 0;
        while ((rd_cnt - rd0) < 2 && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("t6_reads_started", (rd_cnt - rd0) >= 2, 1);
        do_reset();
        p0 = push_cnt;
        repeat (8) @(negedge clk);
        check("t6_no_push_after_rst", push_cnt - p0, 0);
        check("t6_busy_after_rst", busy, 0);
        n0 = meta_log.size();
        send_cmd(16'h0003, 16'h0010, 16'd10, w);
        wait_idle();
        check("t6_meta0", meta_log[n0],   {1'b0, 8'hF8, 16'h0010});
        check("t6_meta1", meta_log[n0+1], {1'b1, 8'h1F, 16'h0015});

        // randomized commands, some back to back
        max_if = 0;
        for (int c = 0; c < 40; c++) begin
            drain_pct = $urandom_range(15, 100);
            s = 16'($urandom);
            d = 16'($urandom);
            l = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 40));
            send_cmd(s, d, l, w);
            if ($urandom_range(0, 1) == 1) wait_idle();
        end
        drain_pct = 70;
        wait_idle();
        check("rand_inflight_max", max_if <= MAX_INFLIGHT, 1);
        check("rand_ovf_err", ovf_err, 0);

        // overflow flag is sticky until reset
        force_full = 1;
        send_cmd(16'h0040, 16'h0000, 16'd8, w);
        wait_idle();
        check("ovf_set", ovf_err, 1);
        force_full = 0;
        do_reset();
        @(negedge clk);
        check("ovf_cleared", ovf_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
